// File: rtl/fifo_win_pkg.sv
// Shared defaults and helpers for the sliding-window FIFO.
// win_pop gives entries popped per read, lane_idx the wrapped lane address.
package fifo_win_pkg;

  localparam int NUM_RDATA_DEF     = 3;
  localparam int STRIDE_DEF        = 1;
  localparam int DAT_WIDTH_DEF     = 8;
  localparam int FF_DEPTH_DEF      = 8;
  localparam int FF_ADDR_WIDTH_DEF = 3;

  function automatic int win_pop(
    input int count,
    input int stride
  );
    return (count < stride) ? count : stride;
  endfunction

  function automatic int lane_idx(
    input int ptr,
    input int lane,
    input int depth
  );
    return (ptr + lane) % depth;
  endfunction

endpackage

// File: rtl/fifo_win_lane_mux.sv
// One window lane: picks mem[(rd_ptr+LANE) mod depth], zero when beyond count.
// Ports: mem_i storage, rd_ptr_i read pointer, count_i occupancy, lane_o data.
import fifo_win_pkg::*;

module fifo_win_lane_mux #(
  parameter int DAT_WIDTH     = DAT_WIDTH_DEF,
  parameter int FF_DEPTH      = FF_DEPTH_DEF,
  parameter int FF_ADDR_WIDTH = FF_ADDR_WIDTH_DEF,
  parameter int LANE          = 0
) (
  input  logic [FF_DEPTH-1:0][DAT_WIDTH-1:0] mem_i,
  input  logic [FF_ADDR_WIDTH-1:0]           rd_ptr_i,
  input  logic [FF_ADDR_WIDTH:0]             count_i,
  output logic [DAT_WIDTH-1:0]               lane_o
);

  logic [FF_ADDR_WIDTH-1:0] addr;

  always_comb begin
    addr = FF_ADDR_WIDTH'(
      lane_idx(int'(rd_ptr_i), LANE, FF_DEPTH));
    lane_o = '0;
    if (int'(count_i) > LANE) begin
      lane_o = mem_i[addr];
    end
  end

endmodule

// File: rtl/fifo_win_rd.sv
// Sliding-window FIFO: each read returns NUM_RDATA entries, pops STRIDE.
// Ports: clk, rst (async low), wr_req/wr_data, rd_req/flush, rd_data/
// rd_data_val, rd_ready, data_counter, full, empty.
// Optional FIFO_WIN_RD_ERR_FLAG_EN adds sticky ovf_err/udf_err outputs.
import fifo_win_pkg::*;

module fifo_win_rd #(
  parameter int NUM_RDATA     = NUM_RDATA_DEF,
  parameter int STRIDE        = STRIDE_DEF,
  parameter int DAT_WIDTH     = DAT_WIDTH_DEF,
  parameter int FF_DEPTH      = FF_DEPTH_DEF,
  parameter int FF_ADDR_WIDTH = FF_ADDR_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_req,
  input  logic [DAT_WIDTH-1:0]           wr_data,
  input  logic                           rd_req,
  input  logic                           flush,
  output logic [DAT_WIDTH*NUM_RDATA-1:0] rd_data,
  output logic                           rd_data_val,
  output logic                           rd_ready,
  output logic [FF_ADDR_WIDTH:0]         data_counter,
  output logic                           full,
`ifdef FIFO_WIN_RD_ERR_FLAG_EN
  output logic                           ovf_err,
  output logic                           udf_err,
`endif
  output logic                           empty
);

  localparam int CW = FF_ADDR_WIDTH + 1;
  localparam int AW = FF_ADDR_WIDTH;
  localparam int WW = DAT_WIDTH * NUM_RDATA;
  localparam logic [CW-1:0] K_C = CW'(NUM_RDATA);
  localparam logic [CW-1:0] D_C = CW'(FF_DEPTH);

  logic [FF_DEPTH-1:0][DAT_WIDTH-1:0] mem_q;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] rd_data_q, rd_data_d;
  logic          rd_val_q, rd_val_d;

  logic          full_c;
  logic          wr_enb;
  logic          rd_enb;
  logic [CW-1:0] pop;
  logic [WW-1:0] win;

  for (genvar i = 0; i < NUM_RDATA; i++) begin : g_lane
    fifo_win_lane_mux #(
      .DAT_WIDTH    (DAT_WIDTH),
      .FF_DEPTH     (FF_DEPTH),
      .FF_ADDR_WIDTH(FF_ADDR_WIDTH),
      .LANE         (i)
    ) u_lane (
      .mem_i   (mem_q),
      .rd_ptr_i(rd_ptr_q),
      .count_i (count_q),
      .lane_o  (win[i*DAT_WIDTH +: DAT_WIDTH])
    );
  end

  always_comb begin
    full_c = (count_q == D_C);
    wr_enb = wr_req & ~full_c;
    // flush widens acceptance to any non-empty partial window
    rd_enb = rd_req &
             ((count_q >= K_C) | (flush & (count_q != '0)));
    pop = '0;
    if (rd_enb) begin
      pop = CW'(win_pop(int'(count_q), STRIDE));
    end
    wr_ptr_d  = wr_ptr_q + AW'(wr_enb);
    // pop may equal FF_DEPTH; truncation keeps it modulo depth
    rd_ptr_d  = rd_ptr_q + pop[AW-1:0];
    count_d   = count_q + CW'(wr_enb) - pop;
    rd_data_d = rd_enb ? win : '0;
    rd_val_d  = rd_enb;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      rd_val_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      rd_val_q  <= rd_val_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_enb) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

`ifdef FIFO_WIN_RD_ERR_FLAG_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q | (wr_req & full_c);
    udf_d = udf_q | (rd_req & ~rd_enb);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_err = ovf_q;
  assign udf_err = udf_q;
`endif

  assign rd_data      = rd_data_q;
  assign rd_data_val  = rd_val_q;
  assign data_counter = count_q;
  assign full         = full_c;
  assign empty        = (count_q == '0);
  assign rd_ready     = (count_q >= K_C);

endmodule

// File: tb/tb_fifo_win_rd.sv
// Bench for fifo_win_rd: stride-1 and stride-2 instances share stimulus,
// each compared against a queue model of the window FIFO.
module tb_fifo_win_rd;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_req = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        rd_req = 1'b0;
  logic        flush = 1'b0;

  logic [23:0] rd_data1, rd_data2;
  logic        val1, val2, rdy1, rdy2;
  logic [3:0]  cnt1, cnt2;
  logic        full1, full2, empty1, empty2;
`ifdef FIFO_WIN_RD_ERR_FLAG_EN
  logic        ovf1, udf1, ovf2, udf2;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]  q1[$];
  logic [7:0]  q2[$];
  logic        e_val1, e_val2;
  logic [23:0] e_dat1, e_dat2;

  always #5 clk = ~clk;

  fifo_win_rd #(.NUM_RDATA(3), .STRIDE(1)) u_dut1 (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data),
    .rd_req(rd_req), .flush(flush), .rd_data(rd_data1),
    .rd_data_val(val1), .rd_ready(rdy1), .data_counter(cnt1),
    .full(full1),
`ifdef FIFO_WIN_RD_ERR_FLAG_EN
    .ovf_err(ovf1), .udf_err(udf1),
`endif
    .empty(empty1)
  );

  fifo_win_rd #(.NUM_RDATA(3), .STRIDE(2)) u_dut2 (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data),
    .rd_req(rd_req), .flush(flush), .rd_data(rd_data2),
    .rd_data_val(val2), .rd_ready(rdy2), .data_counter(cnt2),
    .full(full2),
`ifdef FIFO_WIN_RD_ERR_FLAG_EN
    .ovf_err(ovf2), .udf_err(udf2),
`endif
    .empty(empty2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] win_of(input logic [7:0] q[$]);
    logic [23:0] w = '0;
    for (int i = 0; i < 3; i++)
      if (i < q.size()) w[i*8 +: 8] = q[i];
    return w;
  endfunction

  task automatic check_all();
    chk("u1_val", 32'(val1), 32'(e_val1));
    chk("u1_data", 32'(rd_data1), 32'(e_dat1));
    chk("u1_cnt", 32'(cnt1), q1.size());
    chk("u1_full", 32'(full1), 32'(q1.size() == 8));
    chk("u1_empty", 32'(empty1), 32'(q1.size() == 0));
    chk("u1_rdy", 32'(rdy1), 32'(q1.size() >= 3));
    chk("u2_val", 32'(val2), 32'(e_val2));
    chk("u2_data", 32'(rd_data2), 32'(e_dat2));
    chk("u2_cnt", 32'(cnt2), q2.size());
    chk("u2_full", 32'(full2), 32'(q2.size() == 8));
    chk("u2_empty", 32'(empty2), 32'(q2.size() == 0));
    chk("u2_rdy", 32'(rdy2), 32'(q2.size() >= 3));
  endtask

  // One clock: model update from pre-edge state, then compare outputs.
  task automatic step(input bit wr, input logic [7:0] wd,
                      input bit rd, input bit fl);
    int n1 = q1.size();
    int n2 = q2.size();
    bit acc1 = rd && (n1 >= 3 || (fl && n1 > 0));
    bit acc2 = rd && (n2 >= 3 || (fl && n2 > 0));
    e_val1 = acc1;
    e_val2 = acc2;
    e_dat1 = acc1 ? win_of(q1) : 24'h0;
    e_dat2 = acc2 ? win_of(q2) : 24'h0;
    if (acc1) repeat ((n1 < 1) ? n1 : 1) void'(q1.pop_front());
    if (acc2) repeat ((n2 < 2) ? n2 : 2) void'(q2.pop_front());
    if (wr && n1 < 8) q1.push_back(wd);
    if (wr && n2 < 8) q2.push_back(wd);
    wr_req = wr; wr_data = wd; rd_req = rd; flush = fl;
    @(posedge clk);
    #1;
    wr_req = 1'b0; rd_req = 1'b0; flush = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    q1.delete(); q2.delete();
    e_val1 = 0; e_val2 = 0; e_dat1 = '0; e_dat2 = '0;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    e_val1 = 0; e_val2 = 0; e_dat1 = '0; e_dat2 = '0;
    #12;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // full window read
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    step(0, 0, 1, 0);
    chk("t1_data", 32'(rd_data1), 32'h332211);
    chk("t1_cnt", 32'(cnt1), 2);
    do_reset();

    // partial window needs flush
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(0, 0, 1, 0);
    chk("t2_nofl_val", 32'(val1), 0);
    step(0, 0, 1, 1);
    chk("t2_fl_data", 32'(rd_data1), 32'h002211);
    chk("t2_fl_cnt", 32'(cnt1), 1);
    do_reset();

    // fill, drop extra write, sliding windows
    for (int i = 0; i < 8; i++) step(1, 8'(i), 0, 0);
    chk("t3_full", 32'(full1), 1);
    step(1, 8'hEE, 0, 0);
    chk("t3_drop_cnt", 32'(cnt1), 8);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 0);
      chk("t3_win", 32'(rd_data1),
          {8'(i + 2), 8'(i + 1), 8'(i)});
    end
    do_reset();

    // stride 2
    for (int i = 1; i <= 6; i++) step(1, 8'(i), 0, 0);
    step(0, 0, 1, 0);
    chk("t4_s2_a", 32'(rd_data2), 32'h030201);
    step(0, 0, 1, 0);
    chk("t4_s2_b", 32'(rd_data2), 32'h050403);
    chk("t4_s2_cnt", 32'(cnt2), 2);
    do_reset();

    // pointer wrap: advance both pointers to 6
    for (int i = 0; i < 6; i++) step(1, 8'(i), 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1);
    step(1, 8'hA0, 0, 0);
    step(1, 8'hA1, 0, 0);
    step(1, 8'hA2, 0, 0);
    step(0, 0, 1, 0);
    chk("t5_wrap1", 32'(rd_data1), 32'hA2A1A0);
    chk("t5_wrap2", 32'(rd_data2), 32'hA2A1A0);
    step(1, 8'hA3, 0, 0);
    step(1, 8'hA4, 1, 0);
    chk("t5_conc_cnt", 32'(cnt1), 3);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 6), 8'($urandom),
           ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3));
    end

    // async reset mid-burst with a valid word on the output
    for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0, 0);
    step(1, 8'h5A, 1, 0);
    chk("t6_pre_val", 32'(val1), 1);
    #2;
    do_reset();
    chk("t6_empty", 32'(empty1), 1);

`ifdef FIFO_WIN_RD_ERR_FLAG_EN
    for (int i = 0; i < 8; i++) step(1, 8'(i), 0, 0);
    chk("t7_ovf_pre", 32'(ovf1), 0);
    step(1, 8'hFF, 0, 0);
    chk("t7_ovf_set", 32'(ovf1), 1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("t7_ovf_hold", 32'(ovf1), 1);
    do_reset();
    chk("t7_ovf_clr", 32'(ovf1), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_win_rd.md
Name: fifo_win_rd

Overview:
- Parametrised sliding-window FIFO for the line-buffer path feeding the convolution PEs.
- Each accepted read returns NUM_RDATA consecutive entries as one wide word and pops STRIDE entries.
- A read is accepted only when a full window is present, except during end-of-row flush.
- Supports non-unit stride and flush of partial windows.

Parameters:
- NUM_RDATA, 3: window size K (lanes per read); 1 <= K <= FF_DEPTH.
- STRIDE, 1: entries popped per accepted read; 1 <= STRIDE <= NUM_RDATA.
- DAT_WIDTH, 8: entry width in bits.
- FF_DEPTH, 8: storage depth; must equal 2**FF_ADDR_WIDTH.
- FF_ADDR_WIDTH, 3: address width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- wr_req  in  1  write request.
- wr_data  in  DAT_WIDTH  write data.
- rd_req  in  1  window read request.
- flush  in  1  qualifies rd_req to allow a partial window at end of row.
- rd_data  out  DAT_WIDTH*NUM_RDATA  window; lane i at bits [i*DAT_WIDTH +: DAT_WIDTH]; lane 0 is oldest.
- rd_data_val  out  1  rd_data valid.
- rd_ready  out  1  count >= NUM_RDATA.
- data_counter  out  FF_ADDR_WIDTH+1  current occupancy, 0..FF_DEPTH.
- full  out  1  count == FF_DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (rst=0, async) clears:
  - wr_ptr, rd_ptr and count to 0.
  - rd_data to 0 and rd_data_val to 0.
  - Storage contents are not reset.
  - Reset asserted mid-operation discards all contents immediately.
  - full=0, empty=1 and rd_ready=0 follow from count.
- Write accept: wr_enb = wr_req & ~full.
  - Evaluated on pre-edge count; a simultaneous pop does not free space the same cycle.
  - On accept: mem[wr_ptr] <= wr_data; wr_ptr += 1 modulo FF_DEPTH.
- Read accept:
  - Full window: rd_enb = rd_req & (count >= NUM_RDATA).
  - Partial window: rd_req & flush & (count > 0) & (count < NUM_RDATA) is also accepted.
  - rd_req that is not accepted is dropped silently; rd_data_val stays 0.
- On rd_enb, latency is 1 cycle:
  - Next cycle rd_data_val=1.
  - Lane i = mem[(rd_ptr+i) mod FF_DEPTH] for i < avail, where avail = min(count, NUM_RDATA); lanes >= avail are 0.
  - pop = min(STRIDE, count); rd_ptr += pop modulo FF_DEPTH.
- Cycles without rd_enb: rd_data <= 0, rd_data_val <= 0. Output is a one-cycle pulse, not held.
- Counter update: count <= count + wr_enb - pop, all in FF_ADDR_WIDTH+1 bits; it never wraps.
- Simultaneous write and read: the window reads pre-write storage. The write slot (rd_ptr+count) lies outside the window, so there is no hazard.
- Pointer wrap: all address arithmetic is truncated to FF_ADDR_WIDTH bits, so windows straddling FF_DEPTH-1 -> 0 are contiguous.
- flush=1 with count >= NUM_RDATA behaves as a normal read.
- flush alone, without rd_req, has no effect.

Optional Feature:
- Macro FIFO_WIN_RD_ERR_FLAG_EN.
- When defined, adds outputs ovf_err and udf_err (1 bit each). Both are sticky and cleared only by reset.
  - ovf_err sets the cycle after wr_req & full.
  - udf_err sets the cycle after a rd_req that is not accepted.
- When undefined, neither port nor logic exists and dropped requests are silent.

Decomposition:
- Package fifo_win_pkg holds:
  - Default parameter constants.
  - A function win_pop(count, STRIDE) returning min().
  - A function for lane index modulo FF_DEPTH.
- One natural sub-module: fifo_win_lane_mux, a combinational K-way read-address/zero-fill mux instantiated per lane.
- Top keeps pointers, counter and output register.

Test Plan (defaults: K=3, STRIDE=1, 8-bit, depth 8):
- Write 0x11,0x22,0x33, then rd_req -> next cycle rd_data=0x332211, rd_data_val=1, data_counter 3->2.
- Write 0x11,0x22, then rd_req with flush=0 -> rd_data_val stays 0, data_counter stays 2. Retry with flush=1 -> rd_data=0x002211, data_counter=1.
- Write 8 entries -> full=1. A further write is dropped and data_counter stays 8. Then 6 reads -> windows 0..2, 1..3, ..., 5..7 (data = index).
- STRIDE=2, K=3: write 1..6, read twice -> 0x030201 then 0x050403, data_counter=2.
- Wrap test: pre-advance pointers to 6, write 0xA0,0xA1,0xA2, read -> 0xA2A1A0. Concurrent write+read leaves data_counter unchanged.
- Assert rst low mid-burst (async, between edges) -> all outputs clear immediately, empty=1. With FIFO_WIN_RD_ERR_FLAG_EN, a write while full sets ovf_err and it holds until reset.
